// File: rtl/router_pkg.sv
// Shared constants and types for the router ingress arbiter slice.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic logic [PORT_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = PORT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/router_ingress_arb_if.sv
// Source-side handshake and router-side beat bus of the ingress arbiter.
interface router_ingress_arb_if #(
    parameter int DATA_WIDTH = 32
);
    import router_pkg::*;

    logic [NUM_PORTS-1:0]            src_valid;
    logic [NUM_PORTS-1:0]            src_ready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] src_data;
    logic [NUM_PORTS*PORT_W-1:0]     src_addr;
    logic [NUM_PORTS-1:0]            src_lock;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_en;
    logic [PORT_W-1:0]               out_addr;

    modport master (
        output src_valid, src_data, src_addr, src_lock,
        input  src_ready, out_data, out_en, out_addr
    );

    modport slave (
        input  src_valid, src_data, src_addr, src_lock,
        output src_ready, out_data, out_en, out_addr
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_vld
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx = ptr + PORT_W'(off);
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arb.sv
// Four-source ingress arbiter with round-robin selection and capped locked bursts.
//
// state      | meaning
// ARB_IDLE   | round-robin arbitration from rr_ptr each cycle
// ARB_LOCKED | owner holds the grant until lock drops or MAX_BURST beats
module router_ingress_arb
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    router_ingress_arb_if.slave  bus
);

    localparam logic [3:0] MAX_CNT  = 4'(MAX_BURST);
    localparam bit         CAN_LOCK = (MAX_BURST > 1);

    arb_state_e            state;
    logic [PORT_W-1:0]     rr_ptr;
    logic [PORT_W-1:0]     owner;
    logic [3:0]            beat_cnt;
    logic [NUM_PORTS-1:0]  pick_grant;
    logic                  pick_vld;
    logic [NUM_PORTS-1:0]  ready;
    logic                  xfer;
    logic [PORT_W-1:0]     xfer_idx;
    logic [3:0]            cnt_inc;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_en_q;
    logic [PORT_W-1:0]     out_addr_q;

    rr_pick u_pick (
        .req       (bus.src_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_vld (pick_vld)
    );

    // Grant is gated by resetn so no source sees ready while reset is held.
    always_comb begin
        ready = '0;
        if (resetn) begin
            if (state == ARB_IDLE) ready = pick_grant;
            else                   ready[owner] = bus.src_valid[owner];
        end
    end

    assign xfer     = |ready;
    assign xfer_idx = onehot_idx(ready);
    assign cnt_inc  = beat_cnt + 4'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            out_en_q   <= xfer;
            out_data_q <= xfer ? bus.src_data[xfer_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
            out_addr_q <= xfer ? bus.src_addr[xfer_idx*PORT_W +: PORT_W] : '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        if (bus.src_lock[xfer_idx] && CAN_LOCK) begin
                            state    <= ARB_LOCKED;
                            owner    <= xfer_idx;
                            beat_cnt <= 4'd1;
                        end else begin
                            rr_ptr <= xfer_idx + 2'd1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (bus.src_valid[owner]) begin
                        beat_cnt <= cnt_inc;
                        if (!bus.src_lock[owner] || cnt_inc == MAX_CNT) begin
                            state    <= ARB_IDLE;
                            rr_ptr   <= owner + 2'd1;
                            beat_cnt <= '0;
                        end
                    end else if (!bus.src_lock[owner]) begin
                        state    <= ARB_IDLE;
                        rr_ptr   <= owner + 2'd1;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.src_ready = ready;
    assign bus.out_en    = out_en_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: doc/router_ingress_arb.md
ROUTER_INGRESS_ARB -- requirements
Module: router_ingress_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width per beat.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per locked grant (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port src_valid  input  4  per-source beat valid; bit i is source i.
REQ-006 SHALL have port src_ready  output  4  per-source accept; combinational.
REQ-007 SHALL have port src_data  input  4*DATA_WIDTH  source i payload in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port src_addr  input  8  source i destination in bits [2*i +: 2].
REQ-009 SHALL have port src_lock  input  4  source i requests to keep the grant after the current beat.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered payload to the 4-way router.
REQ-011 SHALL have port out_en  output  1  registered beat strobe to the router.
REQ-012 SHALL have port out_addr  output  2  registered destination to the router.

Function
REQ-013 SHALL accept a beat from source i in a cycle iff src_valid[i] and src_ready[i] are both high (transfer); at most one src_ready bit is high per cycle.
REQ-014 SHALL present each transferred beat on out_data/out_addr with out_en=1 exactly one cycle after the transfer; with no transfer, out_en=0 and out_data/out_addr SHALL be 0 on the following cycle.
REQ-015 SHALL never stall: the router consumes every beat, so the winning source's src_ready SHALL depend only on arbiter state and src_valid.
REQ-016 SHALL implement FSM states IDLE and LOCKED, with registers rr_ptr (2 bits), owner (2 bits), beat_cnt (4 bits).
REQ-017 In IDLE, SHALL grant the first valid source searching rr_ptr, rr_ptr+1, ... modulo 4; no valid source means no grant and no state change.
REQ-018 On an IDLE transfer from source i: if src_lock[i]=1 and MAX_BURST>1, SHALL enter LOCKED with owner=i, beat_cnt=1; otherwise SHALL stay IDLE and set rr_ptr=i+1 mod 4.
REQ-019 In LOCKED, SHALL drive src_ready[owner]=src_valid[owner] and all other src_ready bits 0; owner bubbles (valid low) SHALL leave the grant held.
REQ-020 In LOCKED, on an owner transfer SHALL increment beat_cnt; SHALL return to IDLE with rr_ptr=owner+1 mod 4 when that transfer has src_lock[owner]=0 or beat_cnt reaches MAX_BURST.
REQ-021 In LOCKED, a cycle with src_lock[owner]=0 and src_valid[owner]=0 SHALL return to IDLE with rr_ptr=owner+1 mod 4, no beat emitted.
REQ-022 The cycle after leaving LOCKED SHALL arbitrate normally in IDLE; no idle cycle SHALL be inserted.
REQ-023 src_data/src_addr of non-granted sources SHALL have no effect on any output.

Reset
REQ-024 While resetn=0: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, out_en=0, out_data=0, out_addr=0.
REQ-025 src_ready SHALL be 0 while resetn=0; reset mid-burst SHALL abandon the burst with no further beats emitted.
REQ-026 The first grant after reset release SHALL follow REQ-017 with rr_ptr=0.

Structure
REQ-027 A shared package router_pkg SHALL hold NUM_PORTS=4, PORT_W=2, and the arbiter state enum (ARB_IDLE, ARB_LOCKED).
REQ-028 Round-robin selection SHALL live in one sub-module rr_pick (4-bit request vector + 2-bit pointer in, one-hot grant + valid out, purely combinational).

Verification
REQ-029 Reset: assert resetn=0 mid-locked burst -> src_ready=0, out_en=0, out_data=0 immediately; after release, src_valid=4'b1111 grants source 0 first.
REQ-030 Fairness: src_valid=4'b1111 held, src_lock=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, out_en high every cycle from cycle 2.
REQ-031 Burst cap: source 2 valid and lock held, MAX_BURST=4, source 1 also valid -> four source-2 beats, then source 3 or 0 by rr order (here 3 if valid, else 0, then 1).
REQ-032 Early release: source 1 locks, sends beats with data 0xA, 0xB, drops lock on 0xB -> exactly two beats, addr per beat, IDLE next cycle, rr_ptr=2.
REQ-033 Owner bubble: source 0 locked, valid low 3 cycles with lock high, source 3 valid -> out_en=0 for 3 cycles, source 3 never granted; lock drop with valid low returns to IDLE, source 3 granted next cycle.
REQ-034 Latency/data: single beat src_data=0xDEADBEEF, addr=2'b10 from source 3 -> out_data=0xDEADBEEF, out_addr=2, out_en=1 exactly one cycle later, zeros the cycle after.
